// File: rtl/sv_req_buffer_if.sv
// Request/drain bundle for sv_req_buffer: upstream master handshake plus memory-side req/ack port.
interface sv_req_buffer_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned VALID_W = 3,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  addr;
    logic [VALID_W-1:0] valid;
    logic [DATA_W-1:0]  data;
    logic               wen;
    logic               ren;
    logic               ready;

    logic [ADDR_W-1:0]  m_addr;
    logic [VALID_W-1:0] m_valid;
    logic [DATA_W-1:0]  m_data;
    logic               m_wen;
    logic               m_req;
    logic               m_ack;

    logic [LVL_W-1:0]   level;

    // Environment side: issues requests and acknowledges the memory port.
    modport master (
        output addr, valid, data, wen, ren, m_ack,
        input  ready, m_addr, m_valid, m_data, m_wen, m_req, level
    );

    // Buffer side.
    modport slave (
        input  addr, valid, data, wen, ren, m_ack,
        output ready, m_addr, m_valid, m_data, m_wen, m_req, level
    );
endinterface

// File: rtl/sv_req_buffer.sv
// Request FIFO between the request master and a req/ack memory port, replaying entries in order.
// Optional SV_REQ_BUFFER_STATS_EN adds wr_cnt/rd_cnt counters of popped write/read entries.
module sv_req_buffer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned VALID_W = 3,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    sv_req_buffer_if.slave     bus
`ifdef SV_REQ_BUFFER_STATS_EN
    ,
    output logic [31:0]        wr_cnt,
    output logic [31:0]        rd_cnt
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  addr_q  [DEPTH];
    logic [VALID_W-1:0] valid_q [DEPTH];
    logic [DATA_W-1:0]  data_q  [DEPTH];
    logic               wen_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_q, ready_d;
    logic             m_req_q, m_req_d;

    logic push_c;
    logic pop_c;

    // Both wen and ren count as one request; wen wins when both are set.
    assign push_c = (bus.wen | bus.ren) & ready_q;
    assign pop_c  = m_req_q & bus.m_ack;

    // Pointer and occupancy next state; ready/m_req are registered from the next level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_c && !push_c) begin
            level_d = level_q - LVL_W'(1);
        end
        ready_d = (level_d != LVL_W'(DEPTH));
        m_req_d = (level_d != LVL_W'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
            m_req_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i]  <= '0;
                valid_q[i] <= '0;
                data_q[i]  <= '0;
                wen_q[i]   <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
            m_req_q  <= m_req_d;
            if (push_c) begin
                addr_q[wr_ptr_q]  <= bus.addr;
                valid_q[wr_ptr_q] <= bus.valid;
                data_q[wr_ptr_q]  <= bus.data;
                wen_q[wr_ptr_q]   <= bus.wen;
            end
        end
    end

    assign bus.ready   = ready_q;
    assign bus.m_req   = m_req_q;
    assign bus.level   = level_q;
    assign bus.m_addr  = addr_q[rd_ptr_q];
    assign bus.m_valid = valid_q[rd_ptr_q];
    assign bus.m_data  = data_q[rd_ptr_q];
    assign bus.m_wen   = wen_q[rd_ptr_q];

`ifdef SV_REQ_BUFFER_STATS_EN
    logic [31:0] wr_cnt_q;
    logic [31:0] rd_cnt_q;

    // Pop counters split by entry type; wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (pop_c) begin
            if (wen_q[rd_ptr_q]) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`endif

endmodule
